// File: rtl/fp_pkg.sv
// Shared types and constants for the FP32 adder post-add normalise/round stage.
package fp_pkg;

  typedef struct packed {
    logic       sign;
    logic [7:0] exp;
    logic [22:0] frac;
  } fp32_t;

  localparam logic [7:0]  EXP_MAX    = 8'hFF;
  localparam logic [31:0] FP32_PINF  = 32'h7F80_0000;
  localparam logic [31:0] FP32_PZERO = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } norm_state_e;

endpackage

// File: rtl/fp_lzc32.sv
// Combinational 32-bit leading-zero count; an all-zero input reports 32.
module fp_lzc32 (
  input  logic [31:0] value,
  input  logic        unused_tie,
  output logic [5:0]  count
);

  always_comb begin
    count = 6'd32;
    // Ascending scan: the highest set bit is the last to write count.
    for (int i = 0; i < 32; i++) begin
      if (value[i]) count = 6'(31 - i);
    end
  end

  logic unused_ok;
  assign unused_ok = unused_tie;

endmodule

// File: rtl/fp_norm_round.sv
// FP32 adder post-add stage: renormalise raw sum, round to nearest-even, pack IEEE-754.
// Optional status flags are built only when FP_NORM_ROUND_FLAGS_EN is defined.
module fp_norm_round
  import fp_pkg::*;
#(
  parameter int SHIFT_STEP = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [7:0]  in_exp,
  input  logic [32:0] in_sum,
  input  logic        in_sticky,
  input  logic        in_bypass,
  input  logic [31:0] in_bypass_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_inexact,
  output logic        out_overflow
);

  norm_state_e state;
  logic        sign_r;
  logic        sticky_r;
  logic [8:0]  work_exp;
  logic [31:0] work_sum;
  logic [5:0]  lzc;
  logic [8:0]  exp_room;
  logic [8:0]  shamt;
  logic        accept;
  logic        sum_zero;
  logic        norm_shift;
  fp32_t       rnd_word;

  function automatic fp32_t round_pack(input logic s, input logic [8:0] e,
                                       input logic [31:0] m, input logic stk);
    logic        g, r, st, inc;
    logic [24:0] mant;
    logic [8:0]  e_out;
    fp32_t       res;
    g    = m[7];
    r    = m[6];
    st   = (|m[5:0]) | stk;
    inc  = g & (r | st | m[8]);
    mant = {1'b0, m[31:8]} + 25'(inc);
    // Carry out of rounding renormalises to 1.0; a clear hidden bit is a subnormal.
    if (mant[24])      e_out = e + 9'd1;
    else if (mant[23]) e_out = e;
    else               e_out = 9'd0;
    res.sign = s;
    if ((e >= 9'd255) || (e_out >= 9'd255)) begin
      res.exp  = EXP_MAX;
      res.frac = '0;
    end else begin
      res.exp  = e_out[7:0];
      res.frac = mant[24] ? 23'd0 : mant[22:0];
    end
    return res;
  endfunction

  fp_lzc32 u_lzc (
    .value      (work_sum),
    .unused_tie (1'b0),
    .count      (lzc)
  );

  assign in_ready   = (state == IDLE);
  assign accept     = (state == IDLE) && in_valid;
  assign sum_zero   = (work_sum == 32'd0);
  assign norm_shift = (state == NORM) && !sum_zero && !work_sum[31] && (work_exp > 9'd1);
  assign rnd_word   = round_pack(sign_r, work_exp, work_sum, sticky_r);

  // Shift limited by leading zeros, per-cycle step and the exponent floor of 1.
  always_comb begin
    exp_room = work_exp - 9'd1;
    shamt    = {3'd0, lzc};
    if (9'(SHIFT_STEP) < shamt) shamt = 9'(SHIFT_STEP);
    if (exp_room < shamt)       shamt = exp_room;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      sign_r <= in_sign;
      if (in_sum[32]) begin
        work_sum <= in_sum[32:1];
        sticky_r <= in_sticky | in_sum[0];
        work_exp <= {1'b0, in_exp} + 9'd1;
      end else begin
        work_sum <= in_sum[31:0];
        sticky_r <= in_sticky;
        work_exp <= {1'b0, in_exp};
      end
    end else if (norm_shift) begin
      work_sum <= work_sum << shamt;
      work_exp <= work_exp - shamt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      out_valid  <= 1'b0;
      out_result <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (in_bypass) begin
              state      <= DONE;
              out_valid  <= 1'b1;
              out_result <= in_bypass_result;
            end else begin
              state <= NORM;
            end
          end
        end
        NORM: begin
          if (sum_zero) begin
            state      <= DONE;
            out_valid  <= 1'b1;
            out_result <= FP32_PZERO;
          end else if (work_sum[31] || (work_exp <= 9'd1)) begin
            state <= ROUND;
          end
        end
        ROUND: begin
          state      <= DONE;
          out_valid  <= 1'b1;
          out_result <= rnd_word;
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FP_NORM_ROUND_FLAGS_EN
  logic inexact_r;
  logic overflow_r;

  // Only ROUND can saturate to infinity, so an all-ones exponent there means overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inexact_r  <= 1'b0;
      overflow_r <= 1'b0;
    end else if (state == ROUND) begin
      inexact_r  <= (|work_sum[7:0]) | sticky_r;
      overflow_r <= (rnd_word.exp == EXP_MAX);
    end else if ((accept && in_bypass) || ((state == NORM) && sum_zero)) begin
      inexact_r  <= 1'b0;
      overflow_r <= 1'b0;
    end
  end

  assign out_inexact  = inexact_r;
  assign out_overflow = overflow_r;
`else
  assign out_inexact  = 1'b0;
  assign out_overflow = 1'b0;
`endif

endmodule
